// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared constants and sample/frame types for the 8-point FFT path.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;
    localparam int DEF_WIDTH = 16;

    typedef struct packed {
        logic signed [DEF_WIDTH-1:0] re;
        logic signed [DEF_WIDTH-1:0] im;
    } cplx_t;

    typedef cplx_t [FFT_N-1:0] frame_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_output_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_output_serializer_if
// Purpose  : FFT-result capture inputs and serialized valid/ready output stream.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_output_serializer_if
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic                            fft_ready;
    logic [FFT_N-1:0][WIDTH-1:0]     in_real;
    logic [FFT_N-1:0][WIDTH-1:0]     in_imag;
    logic                            out_valid;
    logic                            out_ready;
    logic [WIDTH-1:0]                out_real;
    logic [WIDTH-1:0]                out_imag;
    logic [FFT_LOG2N-1:0]            out_index;
    logic                            out_last;
    logic                            overflow;
    logic [7:0]                      drop_cnt;

    // master: the serializer; slave: FFT core plus downstream consumer
    modport master (
        input  fft_ready, in_real, in_imag, out_ready,
        output out_valid, out_real, out_imag, out_index, out_last, overflow, drop_cnt
    );

    modport slave (
        output fft_ready, in_real, in_imag, out_ready,
        input  out_valid, out_real, out_imag, out_index, out_last, overflow, drop_cnt
    );

endinterface : fft_output_serializer_if
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_bank
// Purpose  : One 8-entry complex register bank, written whole, read by index.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        i_we,
    input  wire logic [FFT_N-1:0][WIDTH-1:0] i_wr_real,
    input  wire logic [FFT_N-1:0][WIDTH-1:0] i_wr_imag,
    input  wire logic [FFT_LOG2N-1:0]        i_rd_idx,
    output logic      [WIDTH-1:0]            o_rd_real,
    output logic      [WIDTH-1:0]            o_rd_imag
);

    logic [FFT_N-1:0][WIDTH-1:0] r_real;
    logic [FFT_N-1:0][WIDTH-1:0] r_imag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_real <= '0;
            r_imag <= '0;
        end else if (i_we) begin
            r_real <= i_wr_real;
            r_imag <= i_wr_imag;
        end
    end

    assign o_rd_real = r_real[i_rd_idx];
    assign o_rd_imag = r_imag[i_rd_idx];

endmodule : fft_frame_bank
`default_nettype wire

// File: rtl/fft_output_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fft_output_serializer
// Purpose  : Ping-pong capture of 8-bin FFT frames, streamed one bin per beat.
// Revision : 1.0 - initial release
// ============================================================================
module fft_output_serializer
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = 0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    fft_output_serializer_if.master bus
);

    localparam logic [FFT_LOG2N-1:0] c_last_idx = FFT_LOG2N'(FFT_N - 1);
    localparam logic [7:0]           c_drop_max = 8'hFF;
    localparam logic [1:0]           c_full     = 2'd2;

    logic                     r_fft_ready_q;
    logic [1:0]               r_count;
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [FFT_LOG2N-1:0]     r_index;
    logic                     r_overflow;
    logic [7:0]               r_drop_cnt;

    logic                     w_cap_req;
    logic                     w_pop;
    logic                     w_pop_last;
    logic                     w_cap_acc;
    logic                     w_drop;
    logic                     w_valid;
    logic [1:0][WIDTH-1:0]    w_bank_real;
    logic [1:0][WIDTH-1:0]    w_bank_imag;
    logic signed [WIDTH-1:0]  w_rd_real;
    logic signed [WIDTH-1:0]  w_rd_imag;

    assign w_valid    = (r_count != 2'd0);
    assign w_cap_req  = bus.fft_ready & ~r_fft_ready_q;
    assign w_pop      = w_valid & bus.out_ready;
    assign w_pop_last = w_pop & (r_index == c_last_idx);
    // A full buffer still accepts when its oldest frame retires on this edge.
    assign w_cap_acc  = w_cap_req & ((r_count != c_full) | w_pop_last);
    assign w_drop     = w_cap_req & (r_count == c_full) & ~w_pop_last;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        fft_frame_bank #(
            .WIDTH (WIDTH)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_we      (w_cap_acc & (r_wr_ptr == 1'(gi))),
            .i_wr_real (bus.in_real),
            .i_wr_imag (bus.in_imag),
            .i_rd_idx  (r_index),
            .o_rd_real (w_bank_real[gi]),
            .o_rd_imag (w_bank_imag[gi])
        );
    end

    assign w_rd_real = w_bank_real[r_rd_ptr];
    assign w_rd_imag = w_bank_imag[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Held high so a ready level present at reset release is not an edge.
            r_fft_ready_q <= 1'b1;
            r_count       <= 2'd0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_index       <= '0;
            r_overflow    <= 1'b0;
            r_drop_cnt    <= 8'd0;
        end else begin
            r_fft_ready_q <= bus.fft_ready;

            case ({w_cap_acc, w_pop_last})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (w_cap_acc) begin
                r_wr_ptr <= ~r_wr_ptr;
            end

            if (w_pop_last) begin
                r_index  <= '0;
                r_rd_ptr <= ~r_rd_ptr;
            end else if (w_pop) begin
                r_index  <= r_index + 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != c_drop_max) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.out_valid = w_valid;
    assign bus.out_real  = w_rd_real >>> SHIFT;
    assign bus.out_imag  = w_rd_imag >>> SHIFT;
    assign bus.out_index = r_index;
    assign bus.out_last  = w_valid & (r_index == c_last_idx);
    assign bus.overflow  = r_overflow;
    assign bus.drop_cnt  = r_drop_cnt;

endmodule : fft_output_serializer
`default_nettype wire

// File: tb/tb_fft_output_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_output_serializer
// Purpose  : Directed, table-driven self-checking bench for the FFT serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_output_serializer;
    import fft_pkg::*;

    typedef struct {
        logic        rdy;
        logic        valid;
        logic [2:0]  idx;
        logic        last;
        logic [15:0] re;
        logic [15:0] im;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fft_output_serializer_if #(.WIDTH(16)) bus  ();
    fft_output_serializer_if #(.WIDTH(16)) bus2 ();

    fft_output_serializer #(.WIDTH(16), .SHIFT(0)) dut  (.clk(clk), .rst(rst), .bus(bus));
    fft_output_serializer #(.WIDTH(16), .SHIFT(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int   errors = 0;
    int   checks = 0;
    vec_t vecs [48];
    int   nvec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        bus.fft_ready = 1'b1;
        tick();
        bus.fft_ready = 1'b0;
        tick();
    endtask

    task automatic reset_dut();
        rst            = 1'b0;
        bus.fft_ready  = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.fft_ready = 1'b0;
        bus2.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic set_frame(input int rb, input int rs, input int ib, input int is);
        for (int k = 0; k < FFT_N; k++) begin
            bus.in_real[k] = 16'(rb + rs * k);
            bus.in_imag[k] = 16'(ib + is * k);
        end
    endtask

    task automatic add_row(input logic rdy, input logic valid, input int idx, input int re, input int im);
        vecs[nvec].rdy   = rdy;
        vecs[nvec].valid = valid;
        vecs[nvec].idx   = 3'(idx);
        vecs[nvec].last  = valid && (idx == 7);
        vecs[nvec].re    = 16'(re);
        vecs[nvec].im    = 16'(im);
        nvec++;
    endtask

    task automatic add_frame(input int rb, input int rs, input int ib, input int is);
        for (int k = 0; k < FFT_N; k++) add_row(1'b1, 1'b1, k, rb + rs * k, ib + is * k);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < nvec; i++) begin
            bus.out_ready = vecs[i].rdy;
            chk($sformatf("%s[%0d].valid", tag, i), 32'(bus.out_valid), 32'(vecs[i].valid));
            chk($sformatf("%s[%0d].last", tag, i), 32'(bus.out_last), 32'(vecs[i].last));
            if (vecs[i].valid) begin
                chk($sformatf("%s[%0d].index", tag, i), 32'(bus.out_index), 32'(vecs[i].idx));
                chk($sformatf("%s[%0d].real", tag, i), 32'(bus.out_real), 32'(vecs[i].re));
                chk($sformatf("%s[%0d].imag", tag, i), 32'(bus.out_imag), 32'(vecs[i].im));
            end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < FFT_N; k++) begin
            bus.in_real[k]  = '0;
            bus.in_imag[k]  = '0;
            bus2.in_real[k] = '0;
            bus2.in_imag[k] = '0;
        end
        bus.fft_ready  = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.fft_ready = 1'b0;
        bus2.out_ready = 1'b0;
        tick();

        // Reset state, sampled while rst is still low
        chk("rst.valid",    32'(bus.out_valid), 32'd0);
        chk("rst.index",    32'(bus.out_index), 32'd0);
        chk("rst.last",     32'(bus.out_last),  32'd0);
        chk("rst.overflow", 32'(bus.overflow),  32'd0);
        chk("rst.drop_cnt", 32'(bus.drop_cnt),  32'd0);
        chk("rst.real",     32'(bus.out_real),  32'd0);
        chk("rst.imag",     32'(bus.out_imag),  32'd0);
        rst = 1'b1;
        tick();

        // Single frame, out_ready held high
        set_frame(0, 100, 0, -1);
        pulse();
        nvec = 0;
        add_frame(0, 100, 0, -1);
        add_row(1'b1, 1'b0, 0, 0, 0);
        run_table("single");

        // Backpressure 1,0,1,0,...
        pulse();
        nvec = 0;
        for (int j = 0; j < 15; j++) add_row(1'(j % 2 == 0), 1'b1, (j + 1) / 2, 100 * ((j + 1) / 2), -((j + 1) / 2));
        add_row(1'b1, 1'b0, 0, 0, 0);
        run_table("bp");

        // Overflow: A and B accepted, C dropped
        reset_dut();
        set_frame(10, 100, -10, -1);
        pulse();
        set_frame(2000, 3, -2000, 5);
        pulse();
        set_frame(-5000, 7, 4000, -9);
        pulse();
        chk("ovf.overflow", 32'(bus.overflow),  32'd1);
        chk("ovf.drop_cnt", 32'(bus.drop_cnt),  32'd1);
        chk("ovf.count",    32'(dut.r_count),   32'd2);
        chk("ovf.valid",    32'(bus.out_valid), 32'd1);
        nvec = 0;
        add_frame(10, 100, -10, -1);
        add_frame(2000, 3, -2000, 5);
        add_row(1'b1, 1'b0, 0, 0, 0);
        run_table("ovf");

        // Capture edge coinciding with the index-7 pop of a full buffer
        reset_dut();
        set_frame(10, 100, -10, -1);
        pulse();
        set_frame(2000, 3, -2000, 5);
        pulse();
        set_frame(-5000, 7, 4000, -9);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 7; j++) tick();
        chk("sim.index7", 32'(bus.out_index), 32'd7);
        bus.fft_ready = 1'b1;
        tick();
        bus.fft_ready = 1'b0;
        chk("sim.overflow", 32'(bus.overflow), 32'd0);
        chk("sim.drop_cnt", 32'(bus.drop_cnt), 32'd0);
        chk("sim.count",    32'(dut.r_count),  32'd2);
        nvec = 0;
        add_frame(2000, 3, -2000, 5);
        add_frame(-5000, 7, 4000, -9);
        add_row(1'b1, 1'b0, 0, 0, 0);
        run_table("sim");

        // SHIFT=1 instance: floor toward -inf
        reset_dut();
        for (int k = 0; k < FFT_N; k++) begin
            bus2.in_real[k] = 16'(-3 + 8 * k);
            bus2.in_imag[k] = 16'd32767;
        end
        bus2.fft_ready = 1'b1;
        tick();
        bus2.fft_ready = 1'b0;
        chk("shift.valid", 32'(bus2.out_valid), 32'd1);
        chk("shift.real0", 32'(bus2.out_real),  32'h0000FFFE);
        chk("shift.imag0", 32'(bus2.out_imag),  32'h00003FFF);
        bus2.out_ready = 1'b1;
        tick();
        bus2.out_ready = 1'b0;
        chk("shift.real1", 32'(bus2.out_real),  32'd2);

        // Reset asserted during beat 3 with fft_ready held high
        reset_dut();
        set_frame(0, 100, 0, -1);
        bus.fft_ready = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) tick();
        chk("mrst.index3", 32'(bus.out_index), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst.async_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst.async_index", 32'(bus.out_index), 32'd0);
        tick();
        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("mrst.idle[%0d]", j), 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;
        bus.fft_ready = 1'b0;
        tick();
        bus.fft_ready = 1'b1;
        tick();
        bus.fft_ready = 1'b0;
        chk("mrst.restart_valid", 32'(bus.out_valid), 32'd1);
        chk("mrst.restart_index", 32'(bus.out_index), 32'd0);
        chk("mrst.restart_imag",  32'(bus.out_imag),  32'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("mrst.restart_real1", 32'(bus.out_real),  32'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fft_output_serializer
`default_nettype wire

// File: doc/fft_output_serializer.md
Name: fft_output_serializer

Overview:
- Sits directly downstream of the 8-point FFT core. Captures the core's eight complex results when its ready flag rises and streams them out one complex sample per beat over a valid/ready interface.
- Double-buffered (ping-pong), so the core can finish a new frame while the previous one is still draining.
- Frames that arrive with both banks full are dropped, and the drop is flagged.

Parameters:
- WIDTH, 16, bit width of each real/imag component (input and output).
- SHIFT, 0, arithmetic right shift applied to every output component (0..WIDTH-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- fft_ready  input  1  FFT core result-valid level; a 0->1 transition marks a new frame.
- in0_real..in7_real  input  WIDTH each  signed FFT output bins 0..7, real part.
- in0_imag..in7_imag  input  WIDTH each  signed FFT output bins 0..7, imaginary part.
- out_valid  output  1  out_real/out_imag/out_index hold a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_real  output  WIDTH  signed real part of the current bin, after SHIFT.
- out_imag  output  WIDTH  signed imaginary part of the current bin, after SHIFT.
- out_index  output  3  bin number 0..7 of the current beat.
- out_last  output  1  high on the beat with out_index==7.
- overflow  output  1  sticky; set when a frame is dropped.
- drop_cnt  output  8  count of dropped frames, saturates at 255.

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid=0, out_index=0, out_last=0, overflow=0, drop_cnt=0.
  - out_real=0 and out_imag=0 (both banks cleared).
  - Bank occupancy count=0, wr_ptr=0, rd_ptr=0.
  - Edge register fft_ready_q=1, so a ready level held high across reset release never triggers a capture.
- Edge detect: cap_req = fft_ready & ~fft_ready_q. fft_ready_q <= fft_ready on every clock.
- Beat transfer: pop = out_valid & out_ready. pop_last = pop & (out_index==7).
- Capture:
  - Accepted when cap_req & (count<2 | pop_last).
  - On acceptance, all 16 inputs are written into bank[wr_ptr] on that edge and wr_ptr toggles.
- Drop:
  - Occurs when cap_req & count==2 & ~pop_last.
  - Data is discarded; overflow<=1; drop_cnt increments unless it is already 255.
- Occupancy count:
  - +1 on an accepted capture; -1 on pop_last.
  - Both in the same cycle: count unchanged.
  - Range is always 0..2.
- Output side:
  - out_valid = (count!=0).
  - out_real/out_imag = bank[rd_ptr][out_index] >>> SHIFT, arithmetic (floor toward -inf), truncated to WIDTH.
  - On pop: out_index increments. On pop_last: out_index wraps to 0 and rd_ptr toggles.
  - out_last = out_valid & (out_index==7).
- Stability: while out_valid & ~out_ready, out_real, out_imag, out_index and out_last hold constant. A capture only ever writes the bank not being read, except when count==0; in that case the bank being read is the capture target and the new data is valid from the next cycle.
- Latency:
  - Frame captured on edge N with the buffer empty: out_valid=1 and bin 0 presented after edge N.
  - With out_ready held high, bins 0..7 appear on 8 consecutive cycles.
- Throughput: back-to-back frames stream gaplessly when the next frame is captured before the current frame's last pop.
- Reset mid-frame: both banks are discarded and the stream restarts only on a fresh fft_ready rising edge.

Decomposition:
- Shared package fft_pkg:
  - FFT_N=8 and FFT_LOG2N=3.
  - Default WIDTH.
  - Complex sample typedef (signed real, signed imag).
  - 8-entry frame typedef.
- One natural sub-module: fft_frame_bank.
  - Holds one 8-entry complex register bank: write-all-8 on enable, read by 3-bit index.
  - Instantiated twice for ping-pong.

Test Plan:
- Single frame, out_ready=1, inputs real=k*100, imag=-k for bin k:
  - 8 consecutive beats with out_index 0..7.
  - out_real 0,100..700 and out_imag 0,-1..-7.
  - out_last only on index 7; out_valid low afterwards.
- Backpressure, out_ready pattern 1,0,1,0...:
  - Outputs are stable during each low cycle.
  - The frame completes in 16 cycles with values identical to the previous case.
- Overflow, out_ready=0, three fft_ready pulses carrying frames A, B, C:
  - count==2, overflow=1, drop_cnt=1.
  - Draining yields all of A then all of B; C never appears.
- Simultaneous event, count==2 and a fft_ready rising edge on the same cycle as the index-7 pop:
  - Frame accepted, overflow stays 0.
  - Subsequent drain returns the new frame.
- SHIFT=1, inputs real=-3 and imag=32767:
  - out_real=-2 and out_imag=16383.
- Reset mid-stream, rst low during beat 3 with fft_ready held high:
  - out_valid drops immediately (asynchronous).
  - After release, no beats until fft_ready falls and rises again.
